// File: rtl/mips_fetch_unit.sv
// -----------------------------------------------------------------------------
// mips_fetch_unit
//
// Instruction fetch stage for the multi-cycle-memory MIPS core. Holds the PC,
// fetches one 32-bit word per instruction through a ready handshake, latches it
// into the instruction register and computes the next PC from the branch/zero/
// jump results returned by the datapath.
//
// Optional feature: define IF_PERF_CNT_EN to add the instret_cnt/stall_cnt
// performance counters (ports and logic are absent otherwise).
//
// Ports:
//   clk, rst_n      clock (rising edge), async active-low reset
//   imem_req        fetch request (high in FETCH)
//   imem_addr       fetch address, always equal to pc
//   imem_rdata      instruction word, valid with imem_ready
//   imem_ready      memory data valid, sampled only in FETCH
//   branch, zero    branch decode and ALU zero flag (used in EXEC only)
//   jump            jump decode (used in EXEC only, wins over branch)
//   signimm         sign-extended immediate (used in EXEC only)
//   stall           hold the current instruction in EXEC
//   instr, op, funct instruction register and its decoder fields
//   instr_valid     instr may be executed/committed (high in EXEC)
//   pc, pc_plus4    current instruction address and pc + 4
//   instret_cnt     retired instruction count   (IF_PERF_CNT_EN only)
//   stall_cnt       fetch-wait + exec-stall cycles (IF_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [31:0] signimm,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] instret_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   pc_plus4_c;
    logic [XLEN-1:0]   jump_tgt_c;
    logic [XLEN-1:0]   branch_tgt_c;
    logic [XLEN-1:0]   next_pc_c;

    // Sequential address arithmetic; all sums wrap modulo 2^32.
    always_comb begin
        pc_plus4_c   = pc_q + XLEN'(4);
        jump_tgt_c   = {pc_plus4_c[31:28], instr_q[25:0], 2'b00};
        branch_tgt_c = pc_plus4_c + (signimm << 2);
        if (jump) begin
            next_pc_c = jump_tgt_c;
        end else if (branch && zero) begin
            next_pc_c = branch_tgt_c;
        end else begin
            next_pc_c = pc_plus4_c;
        end
    end

    // Next-state logic for FSM, PC and instruction register.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    pc_d    = next_pc_c;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [XLEN-1:0] instret_q;
    logic [XLEN-1:0] stall_q;

    // Retire count on EXEC->FETCH; stall count on fetch waits and exec stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
            stall_q   <= '0;
        end else begin
            if (state_q == ST_EXEC && !stall) begin
                instret_q <= instret_q + XLEN'(1);
            end
            if ((state_q == ST_FETCH && !imem_ready) ||
                (state_q == ST_EXEC && stall)) begin
                stall_q <= stall_q + XLEN'(1);
            end
        end
    end

    assign instret_cnt = instret_q;
    assign stall_cnt   = stall_q;
`endif

    // Outputs decode directly from registered state.
    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ST_EXEC);
    assign instr       = instr_q;
    assign op          = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_c;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_mips_fetch_unit
//
// Scoreboard bench for mips_fetch_unit (RESET_PC = 0x40). The stimulus pushes
// the expected fetch address and instruction word of each instruction; a
// monitor pops and compares on each rising imem_req and rising instr_valid.
// -----------------------------------------------------------------------------
module tb_mips_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [31:0] signimm;
    logic        stall;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef IF_PERF_CNT_EN
    logic [31:0] instret_cnt;
    logic [31:0] stall_cnt;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] addr_q[$];
    logic [31:0] word_q[$];
    logic [31:0] prev_word;

    mips_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .branch     (branch),
        .zero       (zero),
        .jump       (jump),
        .signimm    (signimm),
        .stall      (stall),
        .instr      (instr),
        .op         (op),
        .funct      (funct),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4)
`ifdef IF_PERF_CNT_EN
        ,
        .instret_cnt(instret_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: compare against the scoreboard whenever the DUT presents a
    // new fetch request or a new valid instruction.
    logic req_prev = 1'b0;
    logic val_prev = 1'b0;
    always @(negedge clk) begin
        if (imem_req && !req_prev) begin
            if (addr_q.size() == 0) begin
                check("unexpected_fetch", imem_addr, 32'hxxxx_xxxx);
            end else begin
                check("fetch_addr", imem_addr, addr_q.pop_front());
            end
        end
        if (instr_valid && !val_prev) begin
            if (word_q.size() == 0) begin
                check("unexpected_valid", instr, 32'hxxxx_xxxx);
            end else begin
                logic [31:0] w;
                w = word_q.pop_front();
                check("instr", instr, w);
                check("op", 32'(op), 32'(w[31:26]));
                check("funct", 32'(funct), 32'(w[5:0]));
            end
        end
        req_prev <= imem_req;
        val_prev <= instr_valid;
    end

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            if (imem_req) return;
            @(negedge clk);
        end
        check("req_timeout", 32'(imem_req), 32'd1);
    endtask

    // One instruction: FETCH with rdy_lat wait cycles, EXEC with `stalls`
    // stall cycles, then leave EXEC with the given control inputs.
    task automatic run_instr(input logic [31:0] exp_addr, input logic [31:0] word,
                             input int unsigned rdy_lat, input int unsigned stalls,
                             input logic br, input logic z, input logic j,
                             input logic [31:0] imm);
`ifdef IF_PERF_CNT_EN
        logic [31:0] snap;
`endif
        addr_q.push_back(exp_addr);
        word_q.push_back(word);
        imem_ready = 1'b0;
        imem_rdata = ~word;
        wait_req();
`ifdef IF_PERF_CNT_EN
        snap = stall_cnt;
`endif
        for (int i = 0; i < int'(rdy_lat); i++) begin
            @(negedge clk);
            check("fetch_wait_req", 32'(imem_req), 32'd1);
            check("fetch_wait_instr", instr, prev_word);
            check("fetch_wait_valid", 32'(instr_valid), 32'd0);
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("exec_valid", 32'(instr_valid), 32'd1);
        check("exec_req", 32'(imem_req), 32'd0);
`ifdef IF_PERF_CNT_EN
        check("stall_cnt_fetch", stall_cnt, snap + rdy_lat);
        snap = stall_cnt;
`endif
        stall   = (stalls != 0);
        branch  = br;
        zero    = z;
        jump    = j;
        signimm = imm;
        for (int i = 0; i < int'(stalls); i++) begin
            @(negedge clk);
            check("stall_pc", pc, exp_addr);
            check("stall_instr", instr, word);
            check("stall_valid", 32'(instr_valid), 32'd1);
        end
`ifdef IF_PERF_CNT_EN
        check("stall_cnt_exec", stall_cnt, snap + stalls);
`endif
        stall = 1'b0;
        @(negedge clk);
        // Drive junk controls in FETCH; they must be ignored.
        branch    = 1'b1;
        zero      = 1'b1;
        jump      = 1'b1;
        signimm   = 32'h0000_1234;
        prev_word = word;
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_rdata = 32'h0;
        imem_ready = 1'b1;
        branch     = 1'b0;
        zero       = 1'b0;
        jump       = 1'b0;
        signimm    = 32'h0;
        stall      = 1'b0;
        prev_word  = 32'h0;

        #12;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_pc_plus4", pc_plus4, 32'h0000_0044);
`ifdef IF_PERF_CNT_EN
        check("rst_instret", instret_cnt, 32'h0);
        check("rst_stall_cnt", stall_cnt, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_to_fetch_req", 32'(imem_req), 32'd1);

        // Sequential flow from RESET_PC
        run_instr(32'h0000_0040, 32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        run_instr(32'h0000_0044, 32'h0109_5020, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        // Memory wait of 3 cycles, then j 0x100
        run_instr(32'h0000_0048, 32'h0800_0040, 3, 0, 1'b0, 1'b0, 1'b1, 32'h0);
        // Taken backward branch: 0x104 + (-2<<2) = 0xFC
        run_instr(32'h0000_0100, 32'h1000_FFFE, 0, 0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE);
        run_instr(32'h0000_00FC, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        // Untaken branch falls through to 0x104
        run_instr(32'h0000_0100, 32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE);
        // Two stall cycles, then long branch: 0x108 + 0x0FFF_FEF8 = 0x1000_0000
        run_instr(32'h0000_0104, 32'h1000_FFBE, 0, 2, 1'b1, 1'b1, 1'b0, 32'h03FF_FFBE);
        // Jump wins over taken branch
        run_instr(32'h1000_0000, 32'h0800_0010, 0, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0001);
        // Branch to top of memory: 0x1000_0044 + 0xEFFF_FFB8 = 0xFFFF_FFFC
        run_instr(32'h1000_0040, 32'h1000_FFEE, 1, 0, 1'b1, 1'b1, 1'b0, 32'hFBFF_FFEE);
        // PC wrap to 0
        run_instr(32'hFFFF_FFFC, 32'h0000_0025, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset mid-EXEC aborts the instruction
        addr_q.push_back(32'h0000_0000);
        word_q.push_back(32'h8C08_0004);
        imem_ready = 1'b0;
        wait_req();
        imem_rdata = 32'h8C08_0004;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        stall      = 1'b1;
        branch     = 1'b0;
        zero       = 1'b0;
        jump       = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_pc", pc, RST_PC);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_instr", instr, 32'h0);
        check("midrst_req", 32'(imem_req), 32'd0);
`ifdef IF_PERF_CNT_EN
        check("midrst_stall_cnt", stall_cnt, 32'h0);
`endif
        @(negedge clk);
        stall     = 1'b0;
        rst_n     = 1'b1;
        prev_word = 32'h0;
        run_instr(32'h0000_0040, 32'h0000_000C, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        addr_q.push_back(32'h0000_0044);
        wait_req();
        @(negedge clk);
`ifdef IF_PERF_CNT_EN
        check("instret_after_rst", instret_cnt, 32'd1);
`endif
        check("addr_q_drained", 32'(addr_q.size()), 32'd0);
        check("word_q_drained", 32'(word_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction fetch stage for the multi-cycle-memory variant of the MIPS core. It holds the PC, fetches one 32-bit word per instruction from an instruction memory with a ready handshake, and latches the word into an instruction register. The `op`/`funct` fields from that register drive the control decoder. The datapath returns branch/zero/jump results, and this block uses them to compute the next PC.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset. Must be word-aligned.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address, always equal to `pc`.
- `imem_rdata`  in  32  instruction word; valid when `imem_ready`=1.
- `imem_ready`  in  1  memory has the data; sampled only while in FETCH.
- `branch`  in  1  decoded branch instruction.
- `zero`  in  1  ALU zero flag.
- `jump`  in  1  decoded jump instruction.
- `signimm`  in  32  sign-extended immediate from the datapath.
- `stall`  in  1  hold the current instruction in EXEC.
- `instr`  out  32  instruction register.
- `op`  out  6  `instr[31:26]`.
- `funct`  out  6  `instr[5:0]`.
- `instr_valid`  out  1  `instr` is current and may be executed and committed.
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc + 4`, combinational.
- Only with `IF_PERF_CNT_EN`: `instret_cnt`  out  32, `stall_cnt`  out  32.

## Operation
- FSM states: IDLE, FETCH, EXEC.
- IDLE: state after reset. `imem_req`=0. Unconditionally moves to FETCH on the next edge.
- FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - `imem_ready`=1 at an edge: `instr` <= `imem_rdata`, go to EXEC.
  - `imem_ready`=0: remain in FETCH.
- EXEC: `instr_valid`=1, `imem_req`=0.
  - `stall`=1: remain in EXEC. `pc` and `instr` hold.
  - `stall`=0: `pc` <= `next_pc`, go to FETCH.
- `next_pc` is selected by priority:
  1. `jump`=1: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  2. `branch & zero`: `pc_plus4 + (signimm << 2)`.
  3. Otherwise: `pc_plus4`.
- All address arithmetic is modulo 2^32. `pc`=32'hFFFF_FFFC wraps to 0. A branch target below 0 wraps.
- `branch`, `zero`, `jump` and `signimm` are ignored outside EXEC.
- `instr` holds its value in FETCH until the new word arrives.
- `imem_rdata` is ignored when `imem_ready`=0 or the state is not FETCH.

## Timing
- Reset (async assert, `rst_n`=0) forces immediately:
  - state IDLE, `pc`=`RESET_PC`, `instr`=0 (so `op`=0, `funct`=0)
  - `instr_valid`=0, `imem_req`=0, `imem_addr`=`RESET_PC`, counters=0
- Reset asserted mid-FETCH or mid-EXEC aborts the instruction. No PC update occurs.
- Minimum cost is 2 cycles per instruction: one FETCH cycle with `imem_ready`=1, plus one EXEC cycle.
- After reset deassertion, `imem_req` first rises one cycle later, once the FSM has passed through IDLE.
- `instr_valid` rises in the cycle after the `imem_ready` edge. It is combinational from the state, not registered separately.
- `pc` changes on the edge that leaves EXEC. `imem_addr` shows the new PC in the first FETCH cycle.
- Simultaneous `jump` and `branch & zero`: `jump` wins.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - Adds `instret_cnt`, which increments on each EXEC->FETCH transition.
  - Adds `stall_cnt`, which increments each cycle in FETCH with `imem_ready`=0 or in EXEC with `stall`=1.
  - Both counters are 32-bit, wrap modulo 2^32, and reset to 0.
- Undefined: the counter ports and logic do not exist. All other behaviour is identical.

## Test plan
- Reset with `RESET_PC`=32'h0000_0040 and `imem_ready` tied 1 -> `imem_addr` sequence 0x40, 0x44, 0x48. `instr_valid` alternates 0/1 starting at cycle 2 after release.
- `imem_ready` held low 3 cycles in FETCH -> `imem_req` stays high, `instr` unchanged. EXEC entered on the 4th edge. `stall_cnt`=3 with the macro.
- At `pc`=0x100, `branch`=1, `zero`=1, `signimm`=32'hFFFF_FFFE -> next `imem_addr`=0xFC. Same stimulus with `zero`=0 -> next `imem_addr`=0x104.
- At `pc`=0x1000_0000, `instr`=32'h0800_0010 (j), `jump`=1, `branch`=1, `zero`=1 -> next `imem_addr`=0x1000_0040.
- `stall`=1 for 2 EXEC cycles -> `pc` and `instr` stable, `instr_valid`=1 throughout. `rst_n` pulsed low during EXEC -> `pc`=`RESET_PC`, `instr_valid`=0 immediately. At `pc`=0xFFFF_FFFC with no branch -> next `imem_addr`=0.
